// File: rtl/flt_onboard_axis_seq_checker_if.sv
// AXI4-Stream beat bundle shared by the operand and result channels of the onboard checker.
interface flt_onboard_axis_seq_checker_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int TUSER_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]  tdata;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/flt_onboard_axis_seq_checker.sv
// Onboard operand generator and tlast/tuser order checker for AXI4-Stream float units.
// Optional result backpressure: define FLT_ONBOARD_BACKPRESSURE_EN.
module flt_onboard_axis_seq_checker #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          EXP_WIDTH   = 8,
  parameter int          TUSER_WIDTH = 8,
  parameter int          PKT_LEN     = 16,
  parameter int          NUM_PKTS    = 4,
  parameter int          FIFO_DEPTH  = 32,
  parameter int          TIMEOUT     = 1024,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_0001
) (
  input  logic        i_aclk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  flt_onboard_axis_seq_checker_if.master axi4s_a,
  flt_onboard_axis_seq_checker_if.slave  axi4s_result,
  output logic [15:0] o_err_count,
  output logic [15:0] o_beat_count,
  output logic [15:0] o_latency
);
  localparam int BW = (PKT_LEN > 1)    ? $clog2(PKT_LEN)    : 1;
  localparam int PW = (NUM_PKTS > 1)   ? $clog2(NUM_PKTS)   : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;
  localparam int EW = TUSER_WIDTH + 1;
  localparam logic [EXP_WIDTH-1:0] EXP_BIAS = {1'b0, {(EXP_WIDTH-1){1'b1}}};
  localparam logic [31:0] GALOIS_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

  function automatic logic [31:0] galois_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ GALOIS_MASK) : (v >> 1);
  endfunction

  state_t          state, state_nxt;
  logic [31:0]     lfsr;
  logic [BW-1:0]   beat_idx;
  logic [PW-1:0]   pkt_idx;
  logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     fifo_cnt;
  logic [TW-1:0]   idle_cnt;
  logic [15:0]     err_cnt, beat_cnt, lat_cnt;
  logic            lat_a_seen, lat_r_seen, done, pass;

  logic                 a_hs, r_hs, pop, fifo_empty, fifo_full;
  logic                 last_beat, last_pkt, start_ok, timeout_hit, err_inc;
  logic [16:0]          err_sum;
  logic [EXP_WIDTH-1:0] raw_exp;
  logic [DATA_WIDTH-1:0] operand;
  logic                 unused_result_data;

  assign unused_result_data = ^axi4s_result.tdata;

  assign o_busy = (state == SEND) || (state == DRAIN);

  assign a_hs        = axi4s_a.tvalid & axi4s_a.tready;
  assign r_hs        = axi4s_result.tvalid & axi4s_result.tready;
  assign fifo_empty  = (fifo_cnt == '0);
  assign fifo_full   = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign pop         = r_hs & ~fifo_empty;
  assign last_beat   = (beat_idx == BW'(PKT_LEN - 1));
  assign last_pkt    = (pkt_idx == PW'(NUM_PKTS - 1));
  assign start_ok    = i_start & ((state == IDLE) || (state == DONE));
  assign timeout_hit = (state == DRAIN) & ~axi4s_result.tvalid & (idle_cnt == TW'(TIMEOUT - 1));

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    raw_exp = lfsr[DATA_WIDTH-2 -: EXP_WIDTH];
    operand = lfsr[DATA_WIDTH-1:0];
    if ((raw_exp == '0) || (raw_exp == '1)) operand[DATA_WIDTH-2 -: EXP_WIDTH] = EXP_BIAS;
    err_inc = r_hs & (fifo_empty | (fifo_mem[rd_ptr] != {axi4s_result.tlast, axi4s_result.tuser}));
    err_sum = {1'b0, err_cnt} + {16'd0, err_inc} + (timeout_hit ? 17'(fifo_cnt) : 17'd0);
  end

  // Outputs are zeroed whenever tvalid is low, so idle/reset shows an all-zero bus.
  assign axi4s_a.tvalid = (state == SEND) & ~fifo_full;
  assign axi4s_a.tdata  = axi4s_a.tvalid ? operand : '0;
  assign axi4s_a.tlast  = axi4s_a.tvalid & last_beat;
  assign axi4s_a.tuser  = axi4s_a.tvalid ? TUSER_WIDTH'({pkt_idx, beat_idx}) : '0;

`ifdef FLT_ONBOARD_BACKPRESSURE_EN
  logic [31:0] bp_lfsr;
  always_ff @(posedge i_aclk) begin
    if (i_rst) bp_lfsr <= ~LFSR_SEED;
    else       bp_lfsr <= galois_step(bp_lfsr);
  end
  assign axi4s_result.tready = o_busy & bp_lfsr[5];
`else
  assign axi4s_result.tready = o_busy;
`endif

  always_ff @(posedge i_aclk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (i_start) state_nxt = SEND;
      SEND:       if (a_hs && last_beat && last_pkt) state_nxt = DRAIN;
      DRAIN:      if (fifo_empty || timeout_hit) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // NOTE: the sideband store carries no reset; occupancy and pointers alone define which entries are live.
  always_ff @(posedge i_aclk) begin
    if (a_hs) fifo_mem[wr_ptr] <= {axi4s_a.tlast, axi4s_a.tuser};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_aclk) begin
    if (i_rst || start_ok) begin
      beat_idx   <= '0;
      pkt_idx    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      idle_cnt   <= '0;
      err_cnt    <= '0;
      beat_cnt   <= '0;
      lat_cnt    <= '0;
      lat_a_seen <= 1'b0;
      lat_r_seen <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      if (i_rst) lfsr <= LFSR_SEED;
    end else begin
      if (a_hs) begin
        lfsr     <= galois_step(lfsr);
        wr_ptr   <= wr_ptr + AW'(1);
        beat_idx <= last_beat ? '0 : beat_idx + BW'(1);
        if (last_beat) pkt_idx <= last_pkt ? '0 : pkt_idx + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({a_hs, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (timeout_hit) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fifo_cnt <= '0;
      end

      idle_cnt <= ((state == DRAIN) && !axi4s_result.tvalid) ? idle_cnt + TW'(1) : '0;
      err_cnt  <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (r_hs && (beat_cnt != 16'hFFFF)) beat_cnt <= beat_cnt + 16'd1;

      // Latency counts edges after the first operand handshake up to and including the first result.
      if (!lat_a_seen) begin
        if (a_hs) begin
          lat_a_seen <= 1'b1;
          if (r_hs) lat_r_seen <= 1'b1;
        end
      end else if (!lat_r_seen) begin
        if (lat_cnt != 16'hFFFF) lat_cnt <= lat_cnt + 16'd1;
        if (r_hs) lat_r_seen <= 1'b1;
      end

      if (state == DONE) begin
        done <= 1'b1;
        pass <= (err_cnt == 16'd0);
      end
    end
  end

  assign o_done       = done;
  assign o_pass       = pass;
  assign o_err_count  = err_cnt;
  assign o_beat_count = beat_cnt;
  assign o_latency    = lat_cnt;
endmodule

// File: tb/tb_flt_onboard_axis_seq_checker.sv
// Directed bench: a queue-based latency model stands in for the float unit, with planted sideband faults.
module tb_flt_onboard_axis_seq_checker;
  localparam int DW         = 32;
  localparam int UW         = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 1024;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, pass;
  logic [15:0] err_count, beat_count, latency;

  always #5 clk = ~clk;

  flt_onboard_axis_seq_checker_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) a_if ();
  flt_onboard_axis_seq_checker_if #(.DATA_WIDTH(DW), .TUSER_WIDTH(UW)) r_if ();

  flt_onboard_axis_seq_checker #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .i_aclk       (clk),
    .i_rst        (rst),
    .i_start      (start),
    .o_busy       (busy),
    .o_done       (done),
    .o_pass       (pass),
    .axi4s_a      (a_if),
    .axi4s_result (r_if),
    .o_err_count  (err_count),
    .o_beat_count (beat_count),
    .o_latency    (latency)
  );

  typedef struct {
    logic       tlast;
    logic [7:0] tuser;
    int         ready_at;
  } ent_t;

  ent_t q[$];
  int   model_lat = 3;
  bit   model_toggle = 1'b0;
  int   model_fault = 0;
  bit   clr_stats = 1'b0;

  int          cyc = 0;
  int          a_cnt, r_cnt, max_out, stall_viol, seq_viol, exp_viol, exp_beat, exp_pkt, last_r_cyc;
  logic [31:0] first_tdata, second_tdata, held_data;
  logic [7:0]  held_user;
  logic        held_last, prev_stall;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Device model: every accepted operand reappears as a result model_lat edges later.
  always @(posedge clk) begin : model
    ent_t e;
    logic a_hs, r_hs;
    cyc  = cyc + 1;
    a_hs = a_if.tvalid & a_if.tready;
    r_hs = r_if.tvalid & r_if.tready;
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
      a_if.tready <= 1'b1;
      r_if.tvalid <= 1'b0;
      r_if.tlast  <= 1'b0;
      r_if.tuser  <= '0;
      r_if.tdata  <= '0;
    end else begin
      if (clr_stats) begin
        a_cnt = 0; r_cnt = 0; max_out = 0; stall_viol = 0; seq_viol = 0; exp_viol = 0;
        exp_beat = 0; exp_pkt = 0; last_r_cyc = 0; first_tdata = '0; second_tdata = '0;
      end
      if (prev_stall && (!a_if.tvalid || a_if.tdata !== held_data ||
                         a_if.tuser !== held_user || a_if.tlast !== held_last))
        stall_viol++;
      prev_stall = a_if.tvalid & ~a_if.tready;
      held_data  = a_if.tdata;
      held_user  = a_if.tuser;
      held_last  = a_if.tlast;

      if (r_hs) begin
        r_cnt++;
        last_r_cyc = cyc;
        if (q.size() > 0) void'(q.pop_front());
      end
      if (a_hs) begin
        if (a_cnt == 0) first_tdata = a_if.tdata;
        if (a_cnt == 1) second_tdata = a_if.tdata;
        a_cnt++;
        if (a_if.tuser !== 8'((exp_pkt << 4) | exp_beat) || a_if.tlast !== (exp_beat == 15))
          seq_viol++;
        if (a_if.tdata[30:23] == 8'h00 || a_if.tdata[30:23] == 8'hFF) exp_viol++;
        if (exp_beat == 15) begin
          exp_beat = 0;
          exp_pkt  = (exp_pkt + 1) % 4;
        end else begin
          exp_beat++;
        end
        e.tlast    = a_if.tlast;
        e.tuser    = a_if.tuser;
        e.ready_at = cyc + model_lat;
        if (model_fault == 1 && a_if.tuser == 8'h2F) e.tlast = 1'b0;
        if (!(model_fault == 2 && (a_if.tuser == 8'h3E || a_if.tuser == 8'h3F))) q.push_back(e);
      end
      if (a_cnt - r_cnt > max_out) max_out = a_cnt - r_cnt;

      a_if.tready <= model_toggle ? ~a_if.tready : 1'b1;
      if (q.size() > 0 && q[0].ready_at <= cyc + 1) begin
        r_if.tvalid <= 1'b1;
        r_if.tlast  <= q[0].tlast;
        r_if.tuser  <= q[0].tuser;
        r_if.tdata  <= 32'(cyc);
      end else begin
        r_if.tvalid <= 1'b0;
      end
    end
  end

  task automatic start_run(input int lat, input bit tog, input int fault);
    @(negedge clk);
    model_lat = lat; model_toggle = tog; model_fault = fault; clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int done_cyc);
    int n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    done_cyc = cyc;
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic wait_acnt(input string tag, input int target);
    int n = 0;
    while (a_cnt < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reached"}, 32'(a_cnt >= target), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},   32'(busy),        32'd0);
    check({tag, "_done"},   32'(done),        32'd0);
    check({tag, "_pass"},   32'(pass),        32'd0);
    check({tag, "_err"},    32'(err_count),   32'd0);
    check({tag, "_beats"},  32'(beat_count),  32'd0);
    check({tag, "_lat"},    32'(latency),     32'd0);
    check({tag, "_avalid"}, 32'(a_if.tvalid), 32'd0);
    check({tag, "_adata"},  a_if.tdata,       32'd0);
    check({tag, "_rready"}, 32'(r_if.tready), 32'd0);
  endtask

  initial begin
    int done_cyc;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Clean 3-cycle pipe, always ready.
    start_run(3, 1'b0, 0);
    wait_done("t1", done_cyc);
    check("t1_pass",    32'(pass),       32'd1);
    check("t1_err",     32'(err_count),  32'd0);
    check("t1_beats",   32'(beat_count), 32'd64);
    check("t1_sent",    32'(a_cnt),      32'd64);
`ifndef FLT_ONBOARD_BACKPRESSURE_EN
    check("t1_latency", 32'(latency),    32'd3);
`endif
    check("t1_op0",     first_tdata,     32'hACE1_0001);
    check("t1_op1",     second_tdata,    32'hD650_8003);
    check("t1_seq",     32'(seq_viol),   32'd0);
    check("t1_exp",     32'(exp_viol),   32'd0);
    check("t1_busy",    32'(busy),       32'd0);
    check("t1_rready",  32'(r_if.tready), 32'd0);

    // Alternating operand tready plus a start pulse mid-run that must be ignored.
    start_run(3, 1'b1, 0);
    wait_acnt("t2_mid", 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t2", done_cyc);
    check("t2_pass",   32'(pass),       32'd1);
    check("t2_err",    32'(err_count),  32'd0);
    check("t2_beats",  32'(beat_count), 32'd64);
    check("t2_stable", 32'(stall_viol), 32'd0);
    check("t2_seq",    32'(seq_viol),   32'd0);

    // tlast dropped on packet 2, beat 15.
    start_run(3, 1'b0, 1);
    wait_done("t3", done_cyc);
    check("t3_err",   32'(err_count),  32'd1);
    check("t3_pass",  32'(pass),       32'd0);
    check("t3_beats", 32'(beat_count), 32'd64);

    // Last two results swallowed: DRAIN must time out and charge the leftovers.
    start_run(3, 1'b0, 2);
    wait_done("t4", done_cyc);
    check("t4_err",   32'(err_count),  32'd2);
    check("t4_beats", 32'(beat_count), 32'd62);
    check("t4_pass",  32'(pass),       32'd0);
    check("t4_gap",   32'(done_cyc - last_r_cyc), 32'(TIMEOUT + 1));

    // Reset in the middle of SEND, then a fresh run.
    start_run(3, 1'b0, 0);
    wait_acnt("t5_mid", 20);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("t5_rst");
    start_run(3, 1'b0, 0);
    wait_done("t5", done_cyc);
    check("t5_pass",  32'(pass),       32'd1);
    check("t5_beats", 32'(beat_count), 32'd64);
    check("t5_op0",   first_tdata,     32'hACE1_0001);

    // Long device latency: operand valid must throttle at FIFO_DEPTH outstanding.
    start_run(10, 1'b0, 0);
    wait_done("t6", done_cyc);
    check("t6_maxout", 32'(max_out),    32'(FIFO_DEPTH));
    check("t6_pass",   32'(pass),       32'd1);
    check("t6_err",    32'(err_count),  32'd0);
    check("t6_beats",  32'(beat_count), 32'd64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
